// File: rtl/axil_master_arb.sv
// Two-requester AXI-Lite master arbiter: round-robin grant of one whole read or write transaction at a time.
// Latency: one IDLE cycle to register the grant, then address/data/response forward combinationally.
// Backpressure: the granted port's ready/valid track the master port; the other port sees all zeros and must hold.
module axil_master_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rstn,
  // requester 0 (CPU)
  input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
  input  logic [2:0]            s0_axil_awprot,
  input  logic                  s0_axil_awvalid,
  output logic                  s0_axil_awready,
  input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
  input  logic                  s0_axil_wvalid,
  output logic                  s0_axil_wready,
  output logic [1:0]            s0_axil_bresp,
  output logic                  s0_axil_bvalid,
  input  logic                  s0_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
  input  logic [2:0]            s0_axil_arprot,
  input  logic                  s0_axil_arvalid,
  output logic                  s0_axil_arready,
  output logic [DATA_WIDTH-1:0] s0_axil_rdata,
  output logic [1:0]            s0_axil_rresp,
  output logic                  s0_axil_rvalid,
  input  logic                  s0_axil_rready,
  // requester 1 (loader / debug)
  input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
  input  logic [2:0]            s1_axil_awprot,
  input  logic                  s1_axil_awvalid,
  output logic                  s1_axil_awready,
  input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
  input  logic                  s1_axil_wvalid,
  output logic                  s1_axil_wready,
  output logic [1:0]            s1_axil_bresp,
  output logic                  s1_axil_bvalid,
  input  logic                  s1_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
  input  logic [2:0]            s1_axil_arprot,
  input  logic                  s1_axil_arvalid,
  output logic                  s1_axil_arready,
  output logic [DATA_WIDTH-1:0] s1_axil_rdata,
  output logic [1:0]            s1_axil_rresp,
  output logic                  s1_axil_rvalid,
  input  logic                  s1_axil_rready,
  // shared master port toward the interconnect
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

  state_t state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   rr_last_q, rr_last_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   ar_done_q, ar_done_d;

  // A port requests if any address/data valid is up; a write valid makes it a write.
  logic req0, req1, wr0, wr1;
  assign wr0  = s0_axil_awvalid | s0_axil_wvalid;
  assign wr1  = s1_axil_awvalid | s1_axil_wvalid;
  assign req0 = wr0 | s0_axil_arvalid;
  assign req1 = wr1 | s1_axil_arvalid;

  // Inputs of the currently granted requester.
  logic [ADDR_WIDTH-1:0] sel_awaddr, sel_araddr;
  logic [2:0]            sel_awprot, sel_arprot;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;
  logic                  sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;

  assign sel_awaddr  = gnt_q ? s1_axil_awaddr  : s0_axil_awaddr;
  assign sel_awprot  = gnt_q ? s1_axil_awprot  : s0_axil_awprot;
  assign sel_awvalid = gnt_q ? s1_axil_awvalid : s0_axil_awvalid;
  assign sel_wdata   = gnt_q ? s1_axil_wdata   : s0_axil_wdata;
  assign sel_wstrb   = gnt_q ? s1_axil_wstrb   : s0_axil_wstrb;
  assign sel_wvalid  = gnt_q ? s1_axil_wvalid  : s0_axil_wvalid;
  assign sel_bready  = gnt_q ? s1_axil_bready  : s0_axil_bready;
  assign sel_araddr  = gnt_q ? s1_axil_araddr  : s0_axil_araddr;
  assign sel_arprot  = gnt_q ? s1_axil_arprot  : s0_axil_arprot;
  assign sel_arvalid = gnt_q ? s1_axil_arvalid : s0_axil_arvalid;
  assign sel_rready  = gnt_q ? s1_axil_rready  : s0_axil_rready;

  // Outputs destined for the granted requester; zero outside WR/RD.
  logic                  g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
  logic [1:0]            g_bresp, g_rresp;
  logic [DATA_WIDTH-1:0] g_rdata;

  // State and bookkeeping registers; rr_last resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      rr_last_q <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_done_q <= ar_done_d;
    end
  end

  // Grant selection, channel forwarding with per-channel done gating, and return to IDLE on the response.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    rr_last_d      = rr_last_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    ar_done_d      = ar_done_q;
    m_axil_awaddr  = '0;
    m_axil_awprot  = '0;
    m_axil_awvalid = 1'b0;
    m_axil_wdata   = '0;
    m_axil_wstrb   = '0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_araddr  = '0;
    m_axil_arprot  = '0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    g_awready      = 1'b0;
    g_wready       = 1'b0;
    g_bvalid       = 1'b0;
    g_bresp        = '0;
    g_arready      = 1'b0;
    g_rvalid       = 1'b0;
    g_rresp        = '0;
    g_rdata        = '0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = (req0 && req1) ? ~rr_last_q : req1;
          state_d = (gnt_d ? wr1 : wr0) ? WR : RD;
        end
      end
      WR: begin
        m_axil_awaddr  = sel_awaddr;
        m_axil_awprot  = sel_awprot;
        m_axil_awvalid = sel_awvalid & ~aw_done_q;
        g_awready      = m_axil_awready & ~aw_done_q;
        m_axil_wdata   = sel_wdata;
        m_axil_wstrb   = sel_wstrb;
        m_axil_wvalid  = sel_wvalid & ~w_done_q;
        g_wready       = m_axil_wready & ~w_done_q;
        m_axil_bready  = sel_bready;
        g_bvalid       = m_axil_bvalid;
        g_bresp        = m_axil_bresp;
        if (m_axil_awvalid && m_axil_awready) aw_done_d = 1'b1;
        if (m_axil_wvalid && m_axil_wready)   w_done_d  = 1'b1;
        if (m_axil_bvalid && m_axil_bready) begin
          state_d   = IDLE;
          rr_last_d = gnt_q;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      RD: begin
        m_axil_araddr  = sel_araddr;
        m_axil_arprot  = sel_arprot;
        m_axil_arvalid = sel_arvalid & ~ar_done_q;
        g_arready      = m_axil_arready & ~ar_done_q;
        m_axil_rready  = sel_rready;
        g_rvalid       = m_axil_rvalid;
        g_rdata        = m_axil_rdata;
        g_rresp        = m_axil_rresp;
        if (m_axil_arvalid && m_axil_arready) ar_done_d = 1'b1;
        if (m_axil_rvalid && m_axil_rready) begin
          state_d   = IDLE;
          rr_last_d = gnt_q;
          ar_done_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the granted requester sees ready/valid/data; the other sees zeros.
  assign s0_axil_awready = g_awready & ~gnt_q;
  assign s0_axil_wready  = g_wready  & ~gnt_q;
  assign s0_axil_bvalid  = g_bvalid  & ~gnt_q;
  assign s0_axil_bresp   = gnt_q ? '0 : g_bresp;
  assign s0_axil_arready = g_arready & ~gnt_q;
  assign s0_axil_rvalid  = g_rvalid  & ~gnt_q;
  assign s0_axil_rdata   = gnt_q ? '0 : g_rdata;
  assign s0_axil_rresp   = gnt_q ? '0 : g_rresp;
  assign s1_axil_awready = g_awready & gnt_q;
  assign s1_axil_wready  = g_wready  & gnt_q;
  assign s1_axil_bvalid  = g_bvalid  & gnt_q;
  assign s1_axil_bresp   = gnt_q ? g_bresp : '0;
  assign s1_axil_arready = g_arready & gnt_q;
  assign s1_axil_rvalid  = g_rvalid  & gnt_q;
  assign s1_axil_rdata   = gnt_q ? g_rdata : '0;
  assign s1_axil_rresp   = gnt_q ? g_rresp : '0;

endmodule
